// File: rtl/cache_tag_ctrl.sv
// Tag-lookup and refill controller for a 4-way set-associative tag RAM.
// Holds per-line valid bits, picks a victim on a miss, and sequences the refill.

module cache_tag_way_cmp #(
  parameter int TAG_LEN = 20
) (
  input  logic               line_valid,
  input  logic [TAG_LEN-1:0] stored,
  input  logic [TAG_LEN-1:0] tag,
  output logic               hit
);
  assign hit = line_valid && (stored == tag);
endmodule

module cache_tag_ctrl #(
  parameter int TAG_LEN = 20,
  parameter int LOG_H   = 8,
  parameter int N       = 4,
  parameter int LOG_W   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [LOG_H-1:0]     req_index,
  input  logic [TAG_LEN-1:0]   req_tag,
  output logic [LOG_H-1:0]     tag_addr,
  input  logic [N*TAG_LEN-1:0] tag_rdata,
  output logic                 tag_we,
  output logic [LOG_W-1:0]     tag_way,
  output logic [TAG_LEN-1:0]   tag_wdata,
  output logic                 refill_req,
  input  logic                 refill_ready,
  input  logic                 refill_done,
  output logic                 resp_valid,
  output logic                 resp_hit,
  output logic [LOG_W-1:0]     resp_way
);
  localparam int H = 1 << LOG_H;

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_MISS, S_WAIT, S_WRITE} state_t;

  typedef struct packed {
    logic [LOG_H-1:0]   index;
    logic [TAG_LEN-1:0] tag;
  } req_t;

  state_t                    state;
  req_t                      lat;
  logic [H-1:0][N-1:0]       valid;
  logic [LOG_W-1:0]          rr;
  logic [LOG_W-1:0]          victim;
  logic [N-1:0][TAG_LEN-1:0] ways;
  logic [N-1:0]              set_valid;
  logic [N-1:0]              hit;
  logic                      any_hit;
  logic                      all_valid;
  logic [LOG_W-1:0]          hit_way;
  logic [LOG_W-1:0]          free_way;

  assign ways      = tag_rdata;
  assign set_valid = valid[lat.index];

  for (genvar k = 0; k < N; k++) begin : g_way
    cache_tag_way_cmp #(.TAG_LEN(TAG_LEN)) u_cmp (
      .line_valid (set_valid[k]),
      .stored     (ways[k]),
      .tag        (lat.tag),
      .hit        (hit[k])
    );
  end

  // Scan downward so the lowest-numbered matching way wins.
  always_comb begin
    hit_way  = '0;
    free_way = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (hit[k])        hit_way  = LOG_W'(k);
      if (!set_valid[k]) free_way = LOG_W'(k);
    end
  end

  assign any_hit   = |hit;
  assign all_valid = &set_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      lat    <= '0;
      valid  <= '0;
      rr     <= '0;
      victim <= '0;
    end else begin
      case (state)
        S_IDLE:
          if (req_valid) begin
            lat   <= '{index: req_index, tag: req_tag};
            state <= S_LOOKUP;
          end
        S_LOOKUP:
          if (any_hit) begin
            state <= S_IDLE;
          end else begin
            state <= S_MISS;
            // rr only moves when a valid line must be evicted.
            if (all_valid) begin
              victim <= rr;
              rr     <= rr + LOG_W'(1);
            end else begin
              victim <= free_way;
            end
          end
        S_MISS:  if (refill_ready) state <= S_WAIT;
        S_WAIT:  if (refill_done)  state <= S_WRITE;
        S_WRITE: begin
          valid[lat.index][victim] <= 1'b1;
          state                    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode from state and registers; the hit response is resolved in
  // LOOKUP from the combinational RAM read, never from req_valid.
  assign req_ready  = (state == S_IDLE) && !reset;
  assign tag_addr   = (state == S_IDLE) ? req_index : lat.index;
  assign refill_req = (state == S_MISS);
  assign tag_we     = (state == S_WRITE);
  assign tag_way    = (state == S_WRITE) ? victim  : '0;
  assign tag_wdata  = (state == S_WRITE) ? lat.tag : '0;
  assign resp_valid = ((state == S_LOOKUP) && any_hit) || (state == S_WRITE);
  assign resp_hit   = (state == S_LOOKUP) && any_hit;
  assign resp_way   = ((state == S_LOOKUP) && any_hit) ? hit_way :
                      (state == S_WRITE)               ? victim  : '0;
endmodule

// File: tb/tb_cache_tag_ctrl.sv
// Scoreboarded bench for cache_tag_ctrl with a behavioural tag RAM.
module tb_cache_tag_ctrl;
  localparam int TAG_LEN = 20;
  localparam int LOG_H   = 8;
  localparam int N       = 4;
  localparam int LOG_W   = 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 req_valid;
  logic                 req_ready;
  logic [LOG_H-1:0]     req_index;
  logic [TAG_LEN-1:0]   req_tag;
  logic [LOG_H-1:0]     tag_addr;
  logic [N*TAG_LEN-1:0] tag_rdata;
  logic                 tag_we;
  logic [LOG_W-1:0]     tag_way;
  logic [TAG_LEN-1:0]   tag_wdata;
  logic                 refill_req;
  logic                 refill_ready;
  logic                 refill_done;
  logic                 resp_valid;
  logic                 resp_hit;
  logic [LOG_W-1:0]     resp_way;

  cache_tag_ctrl #(.TAG_LEN(TAG_LEN), .LOG_H(LOG_H), .N(N), .LOG_W(LOG_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_index    (req_index),
    .req_tag      (req_tag),
    .tag_addr     (tag_addr),
    .tag_rdata    (tag_rdata),
    .tag_we       (tag_we),
    .tag_way      (tag_way),
    .tag_wdata    (tag_wdata),
    .refill_req   (refill_req),
    .refill_ready (refill_ready),
    .refill_done  (refill_done),
    .resp_valid   (resp_valid),
    .resp_hit     (resp_hit),
    .resp_way     (resp_way)
  );

  always #5 clk = ~clk;

  // Tag RAM: combinational read, write on the rising edge.
  logic [N*TAG_LEN-1:0] ram [1 << LOG_H];
  assign tag_rdata = ram[tag_addr];
  always @(posedge clk) if (tag_we) ram[tag_addr][tag_way*TAG_LEN +: TAG_LEN] <= tag_wdata;

  typedef struct packed {
    logic             hit;
    logic [LOG_W-1:0] way;
  } resp_t;

  resp_t sb[$];
  int checks = 0;
  int errors = 0;

  // Starts and ends on a negedge with the DUT idle. ready_lat = MISS cycles
  // with refill_ready low; done_lat = WAIT cycles before the refill_done pulse.
  task automatic do_req(input string name, input logic [LOG_H-1:0] idx,
                        input logic [TAG_LEN-1:0] tag, input logic exp_hit,
                        input logic [LOG_W-1:0] exp_way, input int ready_lat,
                        input int done_lat, input bit early_done);
    int cyc, req_cycles, wait_cnt;
    bit accepted, seen, we_seen;
    resp_t exp, got;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL %s req_ready at issue: got %b want 1", name, req_ready);
    end
    req_valid = 1'b1; req_index = idx; req_tag = tag;
    sb.push_back(resp_t'{hit: exp_hit, way: exp_way});
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1; req_cycles = 0; wait_cnt = 0; accepted = 0; seen = 0; we_seen = 0;
    while (!seen && cyc <= 60) begin
      refill_ready = 1'b0; refill_done = 1'b0;
      if (tag_we) begin
        we_seen = 1;
        checks++;
        if (tag_way !== exp_way || tag_wdata !== tag || resp_valid !== 1'b1) begin
          errors++;
          $display("FAIL %s tag write: got way=%0d wdata=%h resp_valid=%b want way=%0d wdata=%h resp_valid=1",
                   name, tag_way, tag_wdata, resp_valid, exp_way, tag);
        end
      end
      if (resp_valid) begin
        seen = 1;
        exp = sb.pop_front();
        got = resp_t'{hit: resp_hit, way: resp_way};
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL %s response: got hit=%b way=%0d want hit=%b way=%0d",
                   name, got.hit, got.way, exp.hit, exp.way);
        end
        checks++;
        if (exp_hit ? (cyc != 1) : (wait_cnt != done_lat + 1)) begin
          errors++;
          $display("FAIL %s response timing: got cycle=%0d wait=%0d want cycle=1 (hit) or wait=%0d (miss)",
                   name, cyc, wait_cnt, done_lat + 1);
        end
      end else if (refill_req) begin
        refill_ready = (req_cycles >= ready_lat);
        refill_done  = early_done && (req_cycles == 1);
        req_cycles++;
        if (refill_ready) accepted = 1;
      end else if (accepted) begin
        refill_done = (wait_cnt == done_lat);
        wait_cnt++;
      end
      if (!seen) begin
        @(negedge clk);
        cyc++;
      end
    end
    if (!seen) begin
      errors++; $display("FAIL %s timeout: no resp_valid within %0d cycles", name, cyc);
      void'(sb.pop_front());
    end
    checks++;
    if (req_cycles != (exp_hit ? 0 : ready_lat + 1) || we_seen == exp_hit) begin
      errors++;
      $display("FAIL %s refill: got refill_req cycles=%0d tag_we=%b want cycles=%0d tag_we=%b",
               name, req_cycles, we_seen, exp_hit ? 0 : ready_lat + 1, !exp_hit);
    end
    refill_ready = 1'b0; refill_done = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL %s req_ready after resp: got %b want 1", name, req_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; req_index = 8'h3C; req_tag = '0;
    refill_ready = 1'b0; refill_done = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({req_ready, tag_we, refill_req, resp_valid, resp_hit, resp_way, tag_way, tag_wdata} !== '0) begin
      errors++;
      $display("FAIL reset outputs: got ready=%b we=%b rreq=%b rv=%b hit=%b rway=%0d tway=%0d wdata=%h want all 0",
               req_ready, tag_we, refill_req, resp_valid, resp_hit, resp_way, tag_way, tag_wdata);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || tag_addr !== 8'h3C) begin
      errors++; $display("FAIL post-reset idle: got ready=%b addr=%h want ready=1 addr=3c", req_ready, tag_addr);
    end
  endtask

  task automatic test_cold_miss_and_hit();
    do_req("cold_miss", 8'h12, 20'hABCDE, 1'b0, 2'd0, 0, 2, 1'b0);
    do_req("hit_after_fill", 8'h12, 20'hABCDE, 1'b1, 2'd0, 0, 0, 1'b0);
    do_req("back_to_back_hit", 8'h12, 20'hABCDE, 1'b1, 2'd0, 0, 0, 1'b0);
  endtask

  task automatic test_round_robin();
    for (int i = 0; i < 4; i++)
      do_req("fill_order", 8'h05, 20'h00100 + 20'(i), 1'b0, LOG_W'(i), 0, 0, 1'b0);
    do_req("evict_rr0", 8'h05, 20'h00104, 1'b0, 2'd0, 0, 0, 1'b0);
    do_req("evict_rr1", 8'h05, 20'h00105, 1'b0, 2'd1, 1, 0, 1'b0);
    do_req("keep_way2", 8'h05, 20'h00102, 1'b1, 2'd2, 0, 0, 1'b0);
    do_req("hit_way1", 8'h05, 20'h00105, 1'b1, 2'd1, 0, 0, 1'b0);
    do_req("evict_rr2", 8'h05, 20'h00101, 1'b0, 2'd2, 0, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    do_req("backpressure", 8'h40, 20'h55555, 1'b0, 2'd0, 5, 1, 1'b1);
  endtask

  task automatic test_reset_in_wait();
    req_valid = 1'b1; req_index = 8'h30; req_tag = 20'h00777;
    @(negedge clk);                 // LOOKUP
    req_valid = 1'b0;
    @(negedge clk);                 // MISS
    refill_ready = 1'b1;
    @(negedge clk);                 // WAIT
    refill_ready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (refill_req !== 1'b0 || resp_valid !== 1'b0 || tag_we !== 1'b0) begin
      errors++; $display("FAIL reset_wait abandon: got rreq=%b rv=%b we=%b want 0 0 0", refill_req, resp_valid, tag_we);
    end
    refill_done = 1'b1;             // stale completion while idle
    @(negedge clk);
    refill_done = 1'b0;
    checks++;
    if (resp_valid !== 1'b0 || tag_we !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_wait stale done: got rv=%b we=%b ready=%b want 0 0 1", resp_valid, tag_we, req_ready);
    end
    do_req("reset_wait_relookup", 8'h30, 20'h00777, 1'b0, 2'd0, 0, 0, 1'b0);
    do_req("reset_cleared_valid", 8'h12, 20'hABCDE, 1'b0, 2'd0, 0, 0, 1'b0);
  endtask

  task automatic test_index_isolation();
    do_req("iso_fill0", 8'h00, 20'h00001, 1'b0, 2'd0, 0, 0, 1'b0);
    do_req("iso_miss1", 8'h01, 20'h00001, 1'b0, 2'd0, 0, 0, 1'b0);
    do_req("iso_hit0", 8'h00, 20'h00001, 1'b1, 2'd0, 0, 0, 1'b0);
    do_req("iso_next_way", 8'h00, 20'h00002, 1'b0, 2'd1, 0, 1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_cold_miss_and_hit();
    test_round_robin();
    test_backpressure();
    test_reset_in_wait();
    test_index_isolation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cache_tag_ctrl.md
# cache_tag_ctrl

Tag-lookup and refill controller placed directly in front of the 4-way cache tag RAM. It accepts one lookup request at a time and reads the tag set through the RAM's combinational read port. It compares the stored tags against the request tag using per-line valid bits held inside this block. On a miss it picks a victim way, performs a refill handshake with the memory side, then writes the new tag into the tag RAM and reports way and hit/miss upstream.

## Interface
- TAG_LEN, 20, tag width in bits
- LOG_H, 8, index width; the cache has H = 2^LOG_H sets
- N, 4, number of ways (fixed at 4)
- LOG_W, 2, way-select width
- clk  in  1  clock; all logic is on the rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  lookup request valid
- req_ready  out  1  controller can accept a request
- req_index  in  LOG_H  set index of the request
- req_tag  in  TAG_LEN  tag of the request
- tag_addr  out  LOG_H  index driven to the tag RAM address
- tag_rdata  in  N*TAG_LEN  tag RAM read data; way k occupies bits [k*TAG_LEN +: TAG_LEN]
- tag_we  out  1  tag RAM write enable
- tag_way  out  LOG_W  way written to the tag RAM
- tag_wdata  out  TAG_LEN  tag written to the tag RAM
- refill_req  out  1  refill request to the memory side
- refill_ready  in  1  memory side accepts refill_req
- refill_done  in  1  refill data has landed (1-cycle pulse)
- resp_valid  out  1  1-cycle response pulse
- resp_hit  out  1  1 = hit, 0 = miss (refilled)
- resp_way  out  LOG_W  way that holds the line

## Operation
- Internal state:
  - valid[H][N] bit array
  - latched index and tag
  - 2-bit round-robin victim counter rr
  - victim register
- FSM states and transitions:
  - IDLE: req_ready = 1. When req_valid is high, latch index and tag, then go to LOOKUP.
  - LOOKUP:
    - hit[k] = valid[idx][k] && tag_rdata way k == latched tag.
    - Any hit: go back to IDLE and pulse resp_valid with resp_hit = 1. resp_way is the lowest-numbered hitting way.
    - No hit: the victim is the lowest-numbered way with valid = 0. If all ways are valid, the victim is rr, and rr increments (wrapping 3 -> 0). Go to MISS.
  - MISS: refill_req = 1. It holds until the cycle where refill_ready = 1, then go to WAIT.
  - WAIT: wait for refill_done = 1, then go to WRITE. A refill_done seen in MISS is ignored.
  - WRITE:
    - tag_we = 1, tag_way = victim, tag_wdata = latched tag; set valid[idx][victim] = 1.
    - Pulse resp_valid with resp_hit = 0 and resp_way = victim, then go to IDLE.
- Address mux: tag_addr = req_index in IDLE; otherwise tag_addr = the latched index.
- rr advances only on a miss where all ways are valid. It does not advance on hits or on fills into invalid ways.
- Reset:
  - state = IDLE; all valid bits = 0; rr = 0; victim = 0.
  - req_ready = 0 during the reset cycle and 1 afterwards.
  - tag_we, refill_req and resp_valid are 0; resp_hit, resp_way, tag_way and tag_wdata are 0.
- Reset in the middle of MISS, WAIT or WRITE:
  - The outstanding operation is abandoned and no response is produced.
  - refill_req is low in the cycle after reset is sampled.
  - A refill_done arriving later is ignored in IDLE.
- Only one request is outstanding at a time; there is no pipelining across requests.

## Timing
- Hit: request accepted at edge T. resp_valid is high in cycle T+1 (LOOKUP), and req_ready returns in T+2.
  - Back-to-back hits therefore accept one request every 2 cycles.
- Miss:
  - LOOKUP in cycle T+1.
  - refill_req is high from cycle T+2 through the first cycle with refill_ready = 1.
  - WRITE occurs in the cycle after refill_done is sampled. tag_we and resp_valid are both high in that same cycle.
- resp_* and tag_* are registered, or decoded from the state alone; none of them depends combinationally on req_valid.
- tag_rdata is sampled in LOOKUP only.
- The tag write in WRITE is visible to a lookup of the same index two cycles later (IDLE, then LOOKUP).

## Test plan
- Cold miss: after reset, request idx 0x12, tag 0xABCDE with refill_ready = 1 and refill_done 3 cycles later -> refill_req for 1 cycle; tag_we with way 0 and wdata 0xABCDE; resp hit = 0, way = 0.
- Hit after fill: repeat idx 0x12, tag 0xABCDE -> resp_valid in the cycle after acceptance, hit = 1, way = 0, no refill_req.
- Fill order and round-robin: 4 distinct tags to idx 0x05 fill ways 0, 1, 2, 3. A 5th and 6th tag evict ways 0 and 1. A lookup of the original way-2 tag still hits way 2.
- Backpressure: refill_ready held low for 5 cycles -> refill_req stays high for all 5 cycles plus the accept cycle; the early refill_done pulse in MISS is ignored; WRITE happens only after a refill_done in WAIT.
- Reset during WAIT -> the next cycle is IDLE with refill_req = 0 and no resp_valid; a subsequent lookup of the same tag misses.
- Index isolation: fill idx 0x00 with tag 0x1 -> lookup idx 0x01 with tag 0x1 misses and uses way 0 of idx 0x01.
